// File: rtl/tx_pkg.sv
// Shared Tx/Rx definitions for OFDM subcarrier mapping: bin type codes,
// mapper FSM states and the bin classification rule.
package tx_pkg;

  typedef enum logic [1:0] {
    BIN_NULL  = 2'd0,
    BIN_PILOT = 2'd1,
    BIN_DATA  = 2'd2
  } bin_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SYM  = 1'b1
  } state_e;

  // step_pilot is a power of two, so the modulo reduces to a mask.
  function automatic bin_type_e bin_type(input logic [31:0] k, input logic [31:0] step_pilot);
    if (k == 32'd0) return BIN_NULL;
    if ((k & (step_pilot - 32'd1)) == 32'd0) return BIN_PILOT;
    return BIN_DATA;
  endfunction

endpackage

// File: rtl/pilot_inserter_if.sv
// Stream bundle for pilot_inserter: data subcarriers in, typed OFDM bins out.
interface pilot_inserter_if #(
  parameter int fft_depth = 12
);
  // Handshake: a beat transfers on a rising clk edge where valid && ready are
  // both high; the source holds its payload stable while valid && !ready, and
  // ready may depend on state but never on the same side's valid.
  logic                        ival;
  logic                        iready;
  logic                        isop;
  logic [2:0]                  index_M_in;
  logic [3:0]                  index_SS_in;
  logic signed [fft_depth-1:0] sub_i;
  logic signed [fft_depth-1:0] sub_q;

  logic                        oval;
  logic                        oready;
  logic                        osop;
  logic                        oeop;
  logic [1:0]                  oindex;
  logic [2:0]                  index_M_out;
  logic [3:0]                  index_SS_out;
  logic signed [fft_depth-1:0] osub_i;
  logic signed [fft_depth-1:0] osub_q;
  logic                        err_sop;

  modport master (
    output ival, isop, index_M_in, index_SS_in, sub_i, sub_q, oready,
    input  iready, oval, osop, oeop, oindex, index_M_out, index_SS_out,
           osub_i, osub_q, err_sop
  );

  modport slave (
    input  ival, isop, index_M_in, index_SS_in, sub_i, sub_q, oready,
    output iready, oval, osop, oeop, oindex, index_M_out, index_SS_out,
           osub_i, osub_q, err_sop
  );
endinterface

// File: rtl/pilot_comb_cnt.sv
// Bin index counter for one OFDM symbol, with the type of the current bin
// decoded one step ahead so it is available as a register.
module pilot_comb_cnt
  import tx_pkg::*;
#(
  parameter int n_log2     = 10,
  parameter int step_pilot = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [n_log2-1:0] k,
  output bin_type_e         btype,
  output logic              last
);

  localparam logic [n_log2-1:0] K_MAX = '1;

  logic [n_log2-1:0] k_next;

  always_comb begin
    k_next = (k == K_MAX) ? '0 : k + 1'b1;
  end

  assign last = (k == K_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k     <= '0;
      btype <= BIN_NULL;
    end else if (clr) begin
      k     <= '0;
      btype <= BIN_NULL;
    end else if (inc) begin
      k     <= k_next;
      btype <= bin_type(32'(k_next), step_pilot);
    end
  end

endmodule

// File: rtl/pilot_inserter.sv
// Tx subcarrier mapper: builds one N-bin OFDM symbol per frame from a data
// subcarrier stream, inserting a null DC bin and a comb of fixed pilots.
module pilot_inserter
  import tx_pkg::*;
#(
  parameter int fft_depth   = 12,
  parameter int n_log2      = 10,
  parameter int step_pilot  = 8,
  parameter int level_pilot = 2000
) (
  input  logic              clk,
  input  logic              rst,
  pilot_inserter_if.slave   bus,
  output state_e            dbg_state
);

  localparam logic signed [fft_depth-1:0] PILOT_I = fft_depth'(level_pilot);

  state_e                      state;
  logic [n_log2-1:0]           k;
  bin_type_e                   btype;
  logic                        last;
  logic                        adv;
  logic                        detect;
  logic                        load;
  logic                        take;
  logic                        first_data;
  logic [2:0]                  m_lat;
  logic [3:0]                  ss_lat;

  logic                        oval_q;
  logic                        osop_q;
  logic                        oeop_q;
  bin_type_e                   oindex_q;
  logic [2:0]                  m_out_q;
  logic [3:0]                  ss_out_q;
  logic signed [fft_depth-1:0] osub_i_q;
  logic signed [fft_depth-1:0] osub_q_q;
  logic                        err_q;

  // The output register may take a new bin when empty or being drained.
  always_comb begin
    adv    = !oval_q || bus.oready;
    detect = (state == ST_IDLE) && bus.ival && bus.isop;
    load   = (state == ST_SYM) && adv && ((btype != BIN_DATA) || bus.ival);
    take   = (state == ST_SYM) && (btype == BIN_DATA) && adv && bus.ival;
  end

  assign bus.iready = (state == ST_SYM) && (btype == BIN_DATA) && adv;

  pilot_comb_cnt #(
    .n_log2     (n_log2),
    .step_pilot (step_pilot)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (detect),
    .inc   (load),
    .k     (k),
    .btype (btype),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      first_data <= 1'b0;
      m_lat      <= '0;
      ss_lat     <= '0;
      oval_q     <= 1'b0;
      osop_q     <= 1'b0;
      oeop_q     <= 1'b0;
      oindex_q   <= BIN_NULL;
      m_out_q    <= '0;
      ss_out_q   <= '0;
      osub_i_q   <= '0;
      osub_q_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // The sop word stays on the input; it is consumed as the k=1 bin.
          if (detect) begin
            m_lat      <= bus.index_M_in;
            ss_lat     <= bus.index_SS_in;
            first_data <= 1'b1;
            state      <= ST_SYM;
          end
        end
        ST_SYM: begin
          if (load && last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (take) begin
        first_data <= 1'b0;
        if (bus.isop && !first_data) err_q <= 1'b1;
      end

      if (adv) begin
        if (load) begin
          oval_q   <= 1'b1;
          osop_q   <= (k == '0);
          oeop_q   <= last;
          oindex_q <= btype;
          if (k == '0) begin
            m_out_q  <= m_lat;
            ss_out_q <= ss_lat;
          end
          case (btype)
            BIN_PILOT: begin
              osub_i_q <= PILOT_I;
              osub_q_q <= '0;
            end
            BIN_DATA: begin
              osub_i_q <= bus.sub_i;
              osub_q_q <= bus.sub_q;
            end
            default: begin
              osub_i_q <= '0;
              osub_q_q <= '0;
            end
          endcase
        end else begin
          oval_q <= 1'b0;
        end
      end
    end
  end

  assign bus.oval         = oval_q;
  assign bus.osop         = osop_q;
  assign bus.oeop         = oeop_q;
  assign bus.oindex       = oindex_q;
  assign bus.index_M_out  = m_out_q;
  assign bus.index_SS_out = ss_out_q;
  assign bus.osub_i       = osub_i_q;
  assign bus.osub_q       = osub_q_q;
  assign bus.err_sop      = err_q;
  assign dbg_state        = state;

endmodule

// File: doc/pilot_inserter.md
# pilot_inserter

Transmit-side subcarrier mapper that builds one frequency-domain OFDM symbol per frame ahead of the Tx IFFT. It accepts a stream of modulated data subcarriers and inserts a null DC bin and fixed-amplitude pilots on a regular comb. It also tags every output bin with a type code, so the receive-side channel estimator and equalizer find pilots at known positions and amplitude. Valid/ready handshake on both sides, one registered output stage.

## Interface
- `fft_depth`, 12: sample width (signed I and Q).
- `n_log2`, 10: log2 of subcarriers per symbol, N = 2^n_log2.
- `step_pilot`, 8: pilot spacing in bins; must be a power of two, ≥2 and < N.
- `level_pilot`, 2000: pilot I amplitude; Q is 0. Must fit `fft_depth` signed.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `ival`  in  1  input data valid.
- `iready`  out  1  input accepted when `ival && iready`.
- `isop`  in  1  marks first data word of a symbol.
- `index_M_in`  in  3  modulation index, sampled at symbol start.
- `index_SS_in`  in  4  stream/slot index, sampled at symbol start.
- `sub_i`, `sub_q`  in  `fft_depth`  signed data subcarrier.
- `oval`  out  1  output bin valid.
- `oready`  in  1  downstream accepts when `oval && oready`.
- `osop`, `oeop`  out  1  first / last bin of symbol (k=0 / k=N-1).
- `oindex`  out  2  bin type: 0 null, 1 pilot, 2 data; 3 unused.
- `index_M_out`, `index_SS_out`  out  3 / 4  indices latched for current symbol.
- `osub_i`, `osub_q`  out  `fft_depth`  signed output bin.
- `err_sop`  out  1  sticky; set on protocol violation, cleared only by reset.

## Operation
- Bin k classification: k=0 → null (0,0); k≠0 and k mod step_pilot = 0 → pilot (level_pilot, 0); otherwise → data, taken from the input stream in order.
- Data words per symbol D = N − N/step_pilot. Defaults: D=896, 127 pilots, 1 null.
- FSM has two states.
  - IDLE: `iready=0`. On `ival && isop`, latch index_M/SS, clear k, go to SYM. The sop word is not consumed in this cycle.
  - SYM: emit bins k=0..N-1 in order. After bin N-1 is loaded into the output register, return to IDLE.
- Advance condition `adv = !oval || oready`.
  - Null/pilot bin: loaded when `adv`; no input is consumed.
  - Data bin: `iready = adv`; the bin is loaded when `ival && adv`; a bubble occurs otherwise.
  - `iready` depends combinationally on `oready` only through `adv`.
- A data word with `isop=1` at data position ≥1 within SYM: set `err_sop`; the word is consumed as ordinary data.
- Any input beat in IDLE without `isop` is held off (`iready=0`). It is never dropped.
- Output register holds its value while `oval && !oready`.

## Timing
- Reset values: `oval=0`, `osop=0`, `oeop=0`, `oindex=0`, `osub_i=0`, `osub_q=0`, `index_M_out=0`, `index_SS_out=0`, `err_sop=0`, `iready=0`, FSM=IDLE, k=0.
- Reset asserted mid-symbol: the partial symbol is abandoned, outputs return to reset values immediately, and no partial output follows.
- Latency: bin k appears on outputs 1 cycle after its load cycle.
- Sop detect to first bin (k=0): 2 cycles.
- Throughput: 1 bin/clock with `oready=1` and the input never starved. N bins in N cycles, plus 1 idle cycle between symbols for the sop detect.
- `index_M_out`/`index_SS_out` change only at the load of k=0.
- Back-to-back: an `isop` presented while bin N-1 is loaded is seen in IDLE on the next cycle.

## Structure
- Shared package `tx_pkg`:
  - bin-type enum (`BIN_NULL=0`, `BIN_PILOT=1`, `BIN_DATA=2`), shared with Rx index decoding;
  - FSM state typedef;
  - function `bin_type(k, step_pilot)`.
- One sub-module, `pilot_comb_cnt`: k counter with wrap at N-1 and registered type decode, feeding the FSM.

## Test plan
- Single symbol at defaults, `oready=1`, input data = ramp 1..896 → 1024 bins; bin 0 = (0,0) type 0; bins 8,16,…,1016 = (2000,0) type 1; bin 1 = 1, bin 9 = 8, bin 1023 = 896; `osop` on k=0, `oeop` on k=1023.
- Random `oready` (50%) and random `ival` gaps → identical bin sequence to the first test; outputs stable while stalled; no data word lost or duplicated.
- Two back-to-back symbols with index_M 3 then 5 → `index_M_out` = 3 for all of symbol 1 and 5 for all of symbol 2; gap of exactly one cycle between symbols.
- `isop` asserted on the 100th data word → `err_sop`=1 and stays 1; the symbol still completes with 1024 bins.
- Reset pulled low at bin 500 → `oval`=0 asynchronously. After release, a new `isop` gives a full symbol starting at k=0.
- `step_pilot`=4, `n_log2`=6 → pilots at 4,8,…,60; 48 data words consumed per symbol.
